sort_input_loader: RTL and testbench

Upstream feeder for the four-entry sort stage. It captures four 4-bit operands one at a time from slide switches, each on a debounced push-button press, and holds them on `x0`..`x3`. After the fourth capture it issues a one-cycle `start` pulse, which is wired to the sort stage's reset so that stage reloads its operands. It then waits for the sort stage's completion flag and re-arms for a new operand set.

---
 rtl/sort_input_loader.sv | 122 ++++++++++++
 tb/tb_sort_input_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sort_input_loader.sv
// Operand loader for the four-entry sort stage: debounces a push button, captures four
// switch operands one press at a time, pulses start and waits for the sort to finish.
module sort_input_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       btn,
    input  logic       sort_done,
    output logic [3:0] x0,
    output logic [3:0] x1,
    output logic [3:0] x2,
    output logic [3:0] x3,
    output logic [1:0] idx,
    output logic       start,
    output logic [1:0] phase
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StHold  = 2'd3
    } state_e;

    logic          sync_meta;
    logic          btn_sync;
    logic          btn_db;
    logic          press;
    logic [CW-1:0] cnt;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] x_q [4];
    logic [3:0] x_d [4];

    // press is raised together with the 0->1 flip of btn_db, so it is valid the cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            btn_sync  <= 1'b0;
            btn_db    <= 1'b0;
            press     <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= btn;
            btn_sync  <= sync_meta;
            press     <= 1'b0;
            if (btn_sync != btn_db) begin
                if (cnt == CntMax) begin
                    btn_db <= ~btn_db;
                    press  <= ~btn_db;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            idx_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        for (int i = 0; i < 4; i++) begin
            x_d[i] = x_q[i];
        end
        unique case (state_q)
            StFill: begin
                if (press) begin
                    x_d[idx_q] = din;
                    idx_d      = idx_q + 2'd1;  // wraps 3 -> 0
                    if (idx_q == 2'd3) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (sort_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (press) begin
                    state_d = StFill;
                    idx_d   = 2'd0;
                end
            end
        endcase
    end

    assign x0    = x_q[0];
    assign x1    = x_q[1];
    assign x2    = x_q[2];
    assign x3    = x_q[3];
    assign idx   = idx_q;
    assign start = (state_q == StStart);
    assign phase = state_q;

endmodule

// File: tb/tb_sort_input_loader.sv
// Self-checking bench for sort_input_loader: directed scenarios plus random button,
// switch and sort_done activity, all compared against a behavioural model every cycle.
module tb_sort_input_loader;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'd0;
    logic       btn = 1'b0;
    logic       sort_done = 1'b0;
    logic [3:0] x0, x1, x2, x3;
    logic [1:0] idx;
    logic       start;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    // Model state: raw-sample history for the debouncer, plain ints for the loader.
    int m_s1, m_sync, m_db, m_press;
    int m_hist[$];
    int m_phase, m_idx;
    int m_x[4];

    sort_input_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .din(din), .btn(btn), .sort_done(sort_done),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .idx(idx), .start(start), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_sync = 0; m_db = 0; m_press = 0;
        m_hist.delete();
        m_phase = 0; m_idx = 0;
        for (int i = 0; i < 4; i++) m_x[i] = 0;
    endtask

    // One rising edge. The debounced level flips once the synchronized button has
    // disagreed with it on D consecutive edges.
    task automatic model_step();
        int  new_press;
        bit  all_diff;
        new_press = 0;
        case (m_phase)
            0: if (m_press != 0) begin
                m_x[m_idx] = int'(din);
                if (m_idx == 3) begin m_idx = 0; m_phase = 1; end
                else m_idx = m_idx + 1;
            end
            1: m_phase = 2;
            2: if (sort_done) m_phase = 3;
            default: if (m_press != 0) begin m_phase = 0; m_idx = 0; end
        endcase
        m_hist.push_back(m_sync);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        all_diff = (m_hist.size() == D);
        foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 1'b0;
        if (all_diff) begin
            m_db = 1 - m_db;
            new_press = m_db;
            m_hist.delete();
        end
        m_press = new_press;
        m_sync  = m_s1;
        m_s1    = int'(btn);
    endtask

    task automatic compare_all();
        check("x0", 32'(x0), 32'(m_x[0]));
        check("x1", 32'(x1), 32'(m_x[1]));
        check("x2", 32'(x2), 32'(m_x[2]));
        check("x3", 32'(x3), 32'(m_x[3]));
        check("idx", 32'(idx), 32'(m_idx));
        check("start", 32'(start), 32'(m_phase == 1));
        check("phase", 32'(phase), 32'(m_phase));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (start) start_cnt++;
        compare_all();
    endtask

    task automatic press_btn(input logic [3:0] d);
        din = d;
        btn = 1'b1;
        repeat (D + 6) cycle();
        btn = 1'b0;
        repeat (D + 4) cycle();
    endtask

    task automatic check_x(input string tag, input logic [15:0] exp);
        check({tag, "_x0"}, 32'(x0), 32'(exp[3:0]));
        check({tag, "_x1"}, 32'(x1), 32'(exp[7:4]));
        check({tag, "_x2"}, 32'(x2), 32'(exp[11:8]));
        check({tag, "_x3"}, 32'(x3), 32'(exp[15:12]));
    endtask

    initial begin
        model_reset();
        #1;
        check_x("rst", 16'h0000);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Four clean presses 3,9,0,F
        press_btn(4'h3);
        check("s1_idx1", 32'(idx), 32'd1);
        press_btn(4'h9);
        check("s1_idx2", 32'(idx), 32'd2);
        press_btn(4'h0);
        check("s1_idx3", 32'(idx), 32'd3);
        start_cnt = 0;
        press_btn(4'hF);
        check("s1_idx0", 32'(idx), 32'd0);
        check("s1_start_pulses", 32'(start_cnt), 32'd1);
        check("s1_phase_wait", 32'(phase), 32'd2);
        check_x("s1", 16'hF093);

        // Presses during WAIT are discarded
        sort_done = 1'b0;
        press_btn(4'h5);
        press_btn(4'h5);
        check("s3_phase_wait", 32'(phase), 32'd2);
        check_x("s3", 16'hF093);
        sort_done = 1'b1;
        cycle();
        check("s3_phase_hold", 32'(phase), 32'd3);
        sort_done = 1'b0;

        // Re-arm from HOLD: first press only returns to FILL
        press_btn(4'hA);
        check("s4_phase_fill", 32'(phase), 32'd0);
        check("s4_idx0", 32'(idx), 32'd0);
        check_x("s4a", 16'hF093);
        press_btn(4'h7);
        check_x("s4b", 16'hF097);
        check("s4_idx1", 32'(idx), 32'd1);

        // Bounce: 2-cycle pulses are filtered, capture 7 edges after the final rise
        din = 4'hC;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1; repeat (2) cycle();
            btn = 1'b0; repeat (2) cycle();
        end
        check("s2_no_capture", 32'(idx), 32'd1);
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k == 6) check("s2_before_edge7", 32'(idx), 32'd1);
            if (k == 7) begin
                check("s2_at_edge7", 32'(idx), 32'd2);
                check("s2_x1", 32'(x1), 32'hC);
            end
        end
        btn = 1'b0;
        repeat (D + 4) cycle();

        // Long hold: exactly one capture
        din = 4'h6;
        btn = 1'b1;
        repeat (100) cycle();
        check("s6_idx", 32'(idx), 32'd3);
        check("s6_x2", 32'(x2), 32'h6);
        btn = 1'b0;
        repeat (D + 4) cycle();
        check("s6_idx_after", 32'(idx), 32'd3);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check_x("s5", 16'h0000);
        check("s5_idx", 32'(idx), 32'd0);
        check("s5_start", 32'(start), 32'd0);
        check("s5_phase", 32'(phase), 32'd0);
        model_reset();
        #1 rst = 1'b0;

        // Random activity against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            din = 4'($urandom());
            sort_done = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
